// File: rtl/tcp_conn_ctrl.sv
// tcp_conn_ctrl
//   Receive-side controller for a single passive-open TCP connection. It
//   consumes parsed segment metadata, runs the LISTEN / SYN_RCVD /
//   ESTABLISHED / LAST_ACK state machine, and tracks rcv_nxt and snd_nxt.
//   It gives a one-cycle accept/drop verdict per consumed segment and issues
//   control segments (SYN|ACK, ACK, FIN|ACK, RST|ACK) to the TX builder.
//   SYN|ACK and FIN|ACK are retransmitted when the retransmit timer expires.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   meta_*              segment metadata from the header parser (valid/ready)
//   rx_window           local receive window, sampled when a request is issued
//   app_abort           level request to reset the connection with RST|ACK
//   tx_req_valid/ready  control segment request handshake to the TX builder
//   tx_*                registered request fields, stable while tx_req_valid
//   verdict_valid/accept one-cycle payload verdict per consumed segment
//   conn_state          LISTEN=0, SYN_RCVD=1, ESTABLISHED=2, LAST_ACK=3
//   peer_window         last window advertised by the peer
module tcp_conn_ctrl #(
   parameter logic [15:0] LOCAL_PORT  = 16'd80,
   parameter logic [31:0] ISS         = 32'h0000_1000,
   parameter int unsigned RTO_CYCLES  = 1000000,
   parameter int unsigned MAX_RETRIES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        meta_valid,
   output logic        meta_ready,
   input  logic [15:0] meta_src_port,
   input  logic [15:0] meta_dst_port,
   input  logic [31:0] meta_seq_num,
   input  logic [31:0] meta_ack_num,
   input  logic [7:0]  meta_flags,
   input  logic [15:0] meta_window_size,
   input  logic [15:0] meta_payload_len,
   input  logic [15:0] rx_window,
   input  logic        app_abort,
   output logic        tx_req_valid,
   input  logic        tx_req_ready,
   output logic [7:0]  tx_flags,
   output logic [31:0] tx_seq,
   output logic [31:0] tx_ack,
   output logic [15:0] tx_src_port,
   output logic [15:0] tx_dst_port,
   output logic [15:0] tx_window,
   output logic        verdict_valid,
   output logic        verdict_accept,
   output logic [1:0]  conn_state,
   output logic [15:0] peer_window
);

   typedef enum logic [1:0] {
      LISTEN      = 2'd0,
      SYN_RCVD    = 2'd1,
      ESTABLISHED = 2'd2,
      LAST_ACK    = 2'd3
   } state_e;

   localparam logic [7:0]  F_FIN       = 8'h01;
   localparam logic [7:0]  F_SYN       = 8'h02;
   localparam logic [7:0]  F_RST       = 8'h04;
   localparam logic [7:0]  F_ACK       = 8'h10;
   localparam logic [31:0] RTO_LAST    = 32'(RTO_CYCLES - 1);
   localparam logic [7:0]  MAX_RETRY_W = 8'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic [31:0] snd_nxt_q, snd_nxt_d;
   logic [31:0] rcv_nxt_q, rcv_nxt_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] peer_port_q, peer_port_d;
   logic [15:0] peer_window_q, peer_window_d;
   logic [7:0]  retry_q, retry_d;
   logic        tx_req_valid_q, tx_req_valid_d;
   logic [7:0]  tx_flags_q, tx_flags_d;
   logic [31:0] tx_seq_q, tx_seq_d;
   logic [31:0] tx_ack_q, tx_ack_d;
   logic [15:0] tx_src_port_q, tx_src_port_d;
   logic [15:0] tx_dst_port_q, tx_dst_port_d;
   logic [15:0] tx_window_q, tx_window_d;
   logic        verdict_valid_q, verdict_valid_d;
   logic        verdict_accept_q, verdict_accept_d;

   logic        consume, abort_go, timing, expire;
   logic        seg_fin, seg_syn, seg_rst, seg_ack;
   logic        issue;
   logic [7:0]  issue_flags;
   logic [31:0] issue_seq, issue_ack;
   logic [31:0] seg_len;
   logic        unused_flags;

   assign seg_fin      = meta_flags[0];
   assign seg_syn      = meta_flags[1];
   assign seg_rst      = meta_flags[2];
   assign seg_ack      = meta_flags[4];
   assign unused_flags = ^{meta_flags[7:5], meta_flags[3]};

   // A pending request or a pending abort stalls the metadata stream.
   assign meta_ready = !rst && !tx_req_valid_q && !(app_abort && (state_q != LISTEN));
   assign consume    = meta_valid && meta_ready;
   assign abort_go   = app_abort && (state_q != LISTEN) && !tx_req_valid_q;
   assign timing     = ((state_q == SYN_RCVD) || (state_q == LAST_ACK)) && !tx_req_valid_q;
   assign expire     = timing && (timer_q == RTO_LAST);

   always_comb begin
      state_d          = state_q;
      snd_nxt_d        = snd_nxt_q;
      rcv_nxt_d        = rcv_nxt_q;
      timer_d          = timer_q;
      peer_port_d      = peer_port_q;
      peer_window_d    = peer_window_q;
      retry_d          = retry_q;
      tx_req_valid_d   = tx_req_valid_q;
      tx_flags_d       = tx_flags_q;
      tx_seq_d         = tx_seq_q;
      tx_ack_d         = tx_ack_q;
      tx_src_port_d    = tx_src_port_q;
      tx_dst_port_d    = tx_dst_port_q;
      tx_window_d      = tx_window_q;
      verdict_valid_d  = consume;
      verdict_accept_d = 1'b0;
      issue            = 1'b0;
      issue_flags      = '0;
      issue_seq        = '0;
      issue_ack        = '0;
      seg_len          = {16'd0, meta_payload_len};

      if (tx_req_valid_q && tx_req_ready) begin
         tx_req_valid_d = 1'b0;
      end
      if (timing) begin
         timer_d = expire ? '0 : timer_q + 32'd1;
      end

      // Priority: abort, then segment consume, then timer expiry. A consume
      // coinciding with expiry only resets the timer (handled above).
      if (abort_go) begin
         issue       = 1'b1;
         issue_flags = F_RST | F_ACK;
         issue_seq   = snd_nxt_q;
         issue_ack   = rcv_nxt_q;
         state_d     = LISTEN;
      end else if (consume) begin
         if ((meta_dst_port != LOCAL_PORT) ||
             ((state_q != LISTEN) && (meta_src_port != peer_port_q))) begin
            // foreign segment: dropped silently
         end else if ((state_q != LISTEN) && seg_rst) begin
            state_d = LISTEN;
         end else begin
            case (state_q)
               LISTEN: begin
                  if (seg_syn && !seg_ack) begin
                     peer_port_d = meta_src_port;
                     rcv_nxt_d   = meta_seq_num + 32'd1;
                     snd_nxt_d   = ISS + 32'd1;
                     issue       = 1'b1;
                     issue_flags = F_SYN | F_ACK;
                     issue_seq   = ISS;
                     issue_ack   = meta_seq_num + 32'd1;
                     state_d     = SYN_RCVD;
                  end
               end
               SYN_RCVD, ESTABLISHED: begin
                  // The ACK completing the handshake carries on through the
                  // established rules so its payload/FIN is not lost.
                  if ((state_q == ESTABLISHED) || (seg_ack && (meta_ack_num == snd_nxt_q))) begin
                     state_d       = ESTABLISHED;
                     peer_window_d = meta_window_size;
                     if (meta_seq_num != rcv_nxt_q) begin
                        issue       = 1'b1;
                        issue_flags = F_ACK;
                        issue_seq   = snd_nxt_q;
                        issue_ack   = rcv_nxt_q;
                     end else if (seg_fin) begin
                        verdict_accept_d = (meta_payload_len != '0);
                        rcv_nxt_d        = rcv_nxt_q + seg_len + 32'd1;
                        issue            = 1'b1;
                        issue_flags      = F_FIN | F_ACK;
                        issue_seq        = snd_nxt_q;
                        issue_ack        = rcv_nxt_q + seg_len + 32'd1;
                        snd_nxt_d        = snd_nxt_q + 32'd1;
                        state_d          = LAST_ACK;
                     end else if (meta_payload_len != '0) begin
                        verdict_accept_d = 1'b1;
                        rcv_nxt_d        = rcv_nxt_q + seg_len;
                        issue            = 1'b1;
                        issue_flags      = F_ACK;
                        issue_seq        = snd_nxt_q;
                        issue_ack        = rcv_nxt_q + seg_len;
                     end
                  end
               end
               LAST_ACK: begin
                  if (seg_ack && (meta_ack_num == snd_nxt_q)) begin
                     state_d = LISTEN;
                  end
               end
               default: ;
            endcase
         end
      end else if (expire) begin
         retry_d = retry_q + 8'd1;
         if (retry_q < MAX_RETRY_W) begin
            // tx_* still hold the last control segment; just re-raise valid.
            tx_req_valid_d = 1'b1;
            tx_window_d    = rx_window;
         end else begin
            state_d = LISTEN;
         end
      end

      if (issue) begin
         tx_req_valid_d = 1'b1;
         tx_flags_d     = issue_flags;
         tx_seq_d       = issue_seq;
         tx_ack_d       = issue_ack;
         tx_src_port_d  = LOCAL_PORT;
         tx_dst_port_d  = peer_port_d;
         tx_window_d    = rx_window;
      end

      if (state_d != state_q) begin
         timer_d = '0;
         retry_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= LISTEN;
         snd_nxt_q        <= ISS;
         rcv_nxt_q        <= '0;
         timer_q          <= '0;
         peer_port_q      <= '0;
         peer_window_q    <= '0;
         retry_q          <= '0;
         tx_req_valid_q   <= 1'b0;
         tx_flags_q       <= '0;
         tx_seq_q         <= '0;
         tx_ack_q         <= '0;
         tx_src_port_q    <= '0;
         tx_dst_port_q    <= '0;
         tx_window_q      <= '0;
         verdict_valid_q  <= 1'b0;
         verdict_accept_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         snd_nxt_q        <= snd_nxt_d;
         rcv_nxt_q        <= rcv_nxt_d;
         timer_q          <= timer_d;
         peer_port_q      <= peer_port_d;
         peer_window_q    <= peer_window_d;
         retry_q          <= retry_d;
         tx_req_valid_q   <= tx_req_valid_d;
         tx_flags_q       <= tx_flags_d;
         tx_seq_q         <= tx_seq_d;
         tx_ack_q         <= tx_ack_d;
         tx_src_port_q    <= tx_src_port_d;
         tx_dst_port_q    <= tx_dst_port_d;
         tx_window_q      <= tx_window_d;
         verdict_valid_q  <= verdict_valid_d;
         verdict_accept_q <= verdict_accept_d;
      end
   end

   assign tx_req_valid   = tx_req_valid_q;
   assign tx_flags       = tx_flags_q;
   assign tx_seq         = tx_seq_q;
   assign tx_ack         = tx_ack_q;
   assign tx_src_port    = tx_src_port_q;
   assign tx_dst_port    = tx_dst_port_q;
   assign tx_window      = tx_window_q;
   assign verdict_valid  = verdict_valid_q;
   assign verdict_accept = verdict_accept_q;
   assign conn_state     = state_q;
   assign peer_window    = peer_window_q;

endmodule

// File: tb/tb_tcp_conn_ctrl.sv
// Self-checking bench for tcp_conn_ctrl: directed scenarios with fixed
// expected values plus randomized traffic compared every cycle against a
// behavioural connection model.
`timescale 1ns/1ps
module tb_tcp_conn_ctrl;

   localparam logic [15:0] LPORT = 16'd80;
   localparam logic [31:0] ISS_V = 32'h0000_1000;
   localparam int unsigned RTO   = 16;
   localparam int unsigned MAXR  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        meta_valid = 1'b0;
   logic        meta_ready;
   logic [15:0] meta_src_port = '0;
   logic [15:0] meta_dst_port = '0;
   logic [31:0] meta_seq_num = '0;
   logic [31:0] meta_ack_num = '0;
   logic [7:0]  meta_flags = '0;
   logic [15:0] meta_window_size = '0;
   logic [15:0] meta_payload_len = '0;
   logic [15:0] rx_window = 16'h4000;
   logic        app_abort = 1'b0;
   logic        tx_req_valid;
   logic        tx_req_ready = 1'b1;
   logic [7:0]  tx_flags;
   logic [31:0] tx_seq, tx_ack;
   logic [15:0] tx_src_port, tx_dst_port, tx_window;
   logic        verdict_valid, verdict_accept;
   logic [1:0]  conn_state;
   logic [15:0] peer_window;

   always #5 clk = ~clk;

   tcp_conn_ctrl #(
      .LOCAL_PORT (LPORT),
      .ISS        (ISS_V),
      .RTO_CYCLES (RTO),
      .MAX_RETRIES(MAXR)
   ) dut (
      .clk(clk), .rst(rst),
      .meta_valid(meta_valid), .meta_ready(meta_ready),
      .meta_src_port(meta_src_port), .meta_dst_port(meta_dst_port),
      .meta_seq_num(meta_seq_num), .meta_ack_num(meta_ack_num),
      .meta_flags(meta_flags), .meta_window_size(meta_window_size),
      .meta_payload_len(meta_payload_len), .rx_window(rx_window),
      .app_abort(app_abort),
      .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
      .tx_flags(tx_flags), .tx_seq(tx_seq), .tx_ack(tx_ack),
      .tx_src_port(tx_src_port), .tx_dst_port(tx_dst_port), .tx_window(tx_window),
      .verdict_valid(verdict_valid), .verdict_accept(verdict_accept),
      .conn_state(conn_state), .peer_window(peer_window)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_state, m_timer, m_retry;
   logic [31:0] m_snd, m_rcv, m_txs, m_txa;
   logic [15:0] m_peer, m_pw, m_txsrc, m_txdst, m_txw;
   logic [7:0]  m_txf;
   bit          m_pend, m_vv, m_va;

   task automatic model_reset();
      m_state = 0; m_timer = 0; m_retry = 0;
      m_snd = ISS_V; m_rcv = 0; m_peer = 0; m_pw = 0;
      m_txs = 0; m_txa = 0; m_txsrc = 0; m_txdst = 0; m_txw = 0; m_txf = 0;
      m_pend = 0; m_vv = 0; m_va = 0;
   endtask

   task automatic model_cycle(output bit consumed);
      bit rdy, abort_go, counting, expire, ok, acc, send;
      int unsigned nxt;
      logic [7:0]  sf;
      logic [31:0] ss, sa, len32;
      rdy      = !m_pend && !(app_abort && m_state != 0);
      consumed = meta_valid && rdy;
      abort_go = app_abort && m_state != 0 && !m_pend;
      counting = (m_state == 1 || m_state == 3) && !m_pend;
      expire   = counting && (m_timer == RTO - 1);
      nxt = m_state; acc = 0; send = 0; sf = 0; ss = 0; sa = 0;
      len32 = {16'd0, meta_payload_len};
      if (m_pend && tx_req_ready) m_pend = 0;
      if (counting) m_timer = expire ? 0 : m_timer + 1;
      if (abort_go) begin
         send = 1; sf = 8'h14; ss = m_snd; sa = m_rcv; nxt = 0;
      end else if (consumed) begin
         ok = (meta_dst_port == LPORT) && (m_state == 0 || meta_src_port == m_peer);
         if (!ok) begin
            nxt = m_state;
         end else if (m_state != 0 && meta_flags[2]) begin
            nxt = 0;
         end else if (m_state == 0) begin
            if (meta_flags[1] && !meta_flags[4]) begin
               m_peer = meta_src_port;
               m_rcv  = meta_seq_num + 1;
               m_snd  = ISS_V + 1;
               send = 1; sf = 8'h12; ss = ISS_V; sa = m_rcv; nxt = 1;
            end
         end else if (m_state == 3) begin
            if (meta_flags[4] && meta_ack_num == m_snd) nxt = 0;
         end else if (m_state == 2 || (meta_flags[4] && meta_ack_num == m_snd)) begin
            nxt  = 2;
            m_pw = meta_window_size;
            if (meta_seq_num != m_rcv) begin
               send = 1; sf = 8'h10; ss = m_snd; sa = m_rcv;
            end else if (meta_flags[0]) begin
               acc   = (len32 != 0);
               m_rcv = m_rcv + len32 + 1;
               send = 1; sf = 8'h11; ss = m_snd; sa = m_rcv;
               m_snd = m_snd + 1;
               nxt   = 3;
            end else if (len32 != 0) begin
               acc   = 1;
               m_rcv = m_rcv + len32;
               send = 1; sf = 8'h10; ss = m_snd; sa = m_rcv;
            end
         end
      end else if (expire) begin
         if (m_retry < MAXR) begin
            m_pend = 1;
            m_txw  = rx_window;
         end else begin
            nxt = 0;
         end
         m_retry = m_retry + 1;
      end
      if (send) begin
         m_pend = 1; m_txf = sf; m_txs = ss; m_txa = sa;
         m_txw = rx_window; m_txsrc = LPORT; m_txdst = m_peer;
      end
      if (nxt != m_state) begin
         m_timer = 0;
         m_retry = 0;
      end
      m_state = nxt;
      m_vv    = consumed;
      m_va    = acc;
   endtask

   task automatic compare_all();
      check_val("tx_req_valid",   32'(tx_req_valid),   32'(m_pend));
      check_val("tx_flags",       32'(tx_flags),       32'(m_txf));
      check_val("tx_seq",         tx_seq,              m_txs);
      check_val("tx_ack",         tx_ack,              m_txa);
      check_val("tx_src_port",    32'(tx_src_port),    32'(m_txsrc));
      check_val("tx_dst_port",    32'(tx_dst_port),    32'(m_txdst));
      check_val("tx_window",      32'(tx_window),      32'(m_txw));
      check_val("verdict_valid",  32'(verdict_valid),  32'(m_vv));
      check_val("verdict_accept", 32'(verdict_accept), 32'(m_va));
      check_val("conn_state",     32'(conn_state),     m_state);
      check_val("peer_window",    32'(peer_window),    32'(m_pw));
   endtask

   // One clock: readiness checked mid-cycle, model advanced with the inputs
   // seen at the edge, registered outputs compared just after the edge.
   task automatic cyc(output bit consumed);
      bit exp_rdy;
      @(negedge clk);
      if (rst) begin
         check_val("meta_ready_rst", 32'(meta_ready), 32'h0);
         model_reset();
         consumed = 0;
      end else begin
         exp_rdy = !m_pend && !(app_abort && m_state != 0);
         check_val("meta_ready", 32'(meta_ready), 32'(exp_rdy));
         model_cycle(consumed);
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      bit c;
      for (int i = 0; i < n; i++) cyc(c);
   endtask

   task automatic send_seg(input logic [15:0] src, input logic [31:0] seq, input logic [31:0] ack,
                           input logic [7:0] flags, input logic [15:0] len);
      bit c;
      int n;
      meta_valid = 1'b1; meta_src_port = src; meta_dst_port = LPORT;
      meta_seq_num = seq; meta_ack_num = ack; meta_flags = flags;
      meta_payload_len = len; meta_window_size = 16'h2000 + len;
      c = 0; n = 0;
      while (!c && n < 200) begin
         cyc(c);
         n++;
      end
      check_val("send_consumed", 32'(c), 32'h1);
      meta_valid = 1'b0;
   endtask

   task automatic gen_seg();
      int r;
      meta_dst_port    = ($urandom_range(0, 9) == 0) ? 16'($urandom) : LPORT;
      meta_src_port    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1000, 1003)) : 16'd5000;
      meta_seq_num     = ($urandom_range(0, 3) == 0) ? m_rcv + $urandom_range(1, 50) : m_rcv;
      meta_ack_num     = ($urandom_range(0, 3) == 0) ? $urandom : m_snd;
      meta_payload_len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      meta_window_size = 16'($urandom);
      r = $urandom_range(0, 99);
      if (m_state == 0) begin
         meta_seq_num = $urandom;
         meta_flags   = (r < 50) ? 8'h02 : 8'($urandom);
      end else if (r < 50) meta_flags = 8'h18;
      else if (r < 65)     meta_flags = 8'h10;
      else if (r < 77)     meta_flags = 8'h11;
      else if (r < 80)     meta_flags = 8'h04;
      else                 meta_flags = 8'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit c;
      int reqs;
      bit prev;
      model_reset();
      idle(2);
      check_val("rst_conn_state", 32'(conn_state), 32'h0);
      check_val("rst_tx_valid", 32'(tx_req_valid), 32'h0);
      rst = 1'b0;
      idle(1);

      // handshake, in-order data, duplicate, passive close
      send_seg(16'd5000, 32'h100, 32'h0, 8'h02, 16'd0);
      check_val("synack_flags", 32'(tx_flags), 32'h12);
      check_val("synack_seq", tx_seq, 32'h1000);
      check_val("synack_ack", tx_ack, 32'h101);
      check_val("synack_dst", 32'(tx_dst_port), 32'd5000);
      check_val("synack_src", 32'(tx_src_port), 32'd80);
      check_val("state_syn_rcvd", 32'(conn_state), 32'd1);
      send_seg(16'd5000, 32'h101, 32'h1001, 8'h10, 16'd0);
      check_val("state_est", 32'(conn_state), 32'd2);
      send_seg(16'd5000, 32'h101, 32'h1001, 8'h18, 16'd10);
      check_val("data_accept", 32'(verdict_accept), 32'h1);
      check_val("data_ack_flags", 32'(tx_flags), 32'h10);
      check_val("data_ack", tx_ack, 32'h10B);
      send_seg(16'd5000, 32'h101, 32'h1001, 8'h18, 16'd10);
      check_val("dup_verdict_valid", 32'(verdict_valid), 32'h1);
      check_val("dup_accept", 32'(verdict_accept), 32'h0);
      check_val("dup_ack", tx_ack, 32'h10B);
      send_seg(16'd5000, 32'h10B, 32'h1001, 8'h11, 16'd0);
      check_val("fin_flags", 32'(tx_flags), 32'h11);
      check_val("fin_seq", tx_seq, 32'h1001);
      check_val("fin_ack", tx_ack, 32'h10C);
      check_val("state_last_ack", 32'(conn_state), 32'd3);
      send_seg(16'd5000, 32'h10C, 32'h1002, 8'h10, 16'd0);
      check_val("state_closed", 32'(conn_state), 32'd0);
      idle(2);

      // backpressure
      send_seg(16'd5000, 32'h500, 32'h0, 8'h02, 16'd0);
      send_seg(16'd5000, 32'h501, 32'h1001, 8'h10, 16'd0);
      tx_req_ready = 1'b0;
      send_seg(16'd5000, 32'h501, 32'h1001, 8'h18, 16'd4);
      meta_valid = 1'b1; meta_seq_num = 32'h505; meta_flags = 8'h18; meta_payload_len = 16'd4;
      for (int i = 0; i < 20; i++) begin
         cyc(c);
         check_val("bp_ready", 32'(meta_ready), 32'h0);
         check_val("bp_valid", 32'(tx_req_valid), 32'h1);
         check_val("bp_ack", tx_ack, 32'h505);
         check_val("bp_flags", 32'(tx_flags), 32'h10);
      end
      tx_req_ready = 1'b1;
      send_seg(16'd5000, 32'h505, 32'h1001, 8'h18, 16'd4);
      check_val("bp_next_accept", 32'(verdict_accept), 32'h1);
      check_val("bp_next_ack", tx_ack, 32'h509);
      send_seg(16'd5000, 32'h509, 32'h0, 8'h04, 16'd0);
      check_val("rst_to_listen", 32'(conn_state), 32'd0);
      idle(2);

      // retransmit of SYN|ACK, then abandon
      send_seg(16'd5000, 32'h900, 32'h0, 8'h02, 16'd0);
      reqs = 1; prev = 1;
      for (int i = 0; i < 300 && conn_state != 2'd0; i++) begin
         cyc(c);
         if (tx_req_valid && !prev) reqs++;
         prev = tx_req_valid;
      end
      check_val("retx_requests", 32'(reqs), 32'd4);
      check_val("retx_state", 32'(conn_state), 32'd0);
      check_val("retx_seq", tx_seq, 32'h1000);
      check_val("retx_ack", tx_ack, 32'h901);
      idle(2);

      // sequence wrap, then abort against a waiting segment
      send_seg(16'd5000, 32'hFFFF_FFFB, 32'h0, 8'h02, 16'd0);
      check_val("wrap_synack_ack", tx_ack, 32'hFFFF_FFFC);
      send_seg(16'd5000, 32'hFFFF_FFFC, 32'h1001, 8'h10, 16'd0);
      send_seg(16'd5000, 32'hFFFF_FFFC, 32'h1001, 8'h18, 16'd8);
      check_val("wrap_ack", tx_ack, 32'h0000_0004);
      check_val("wrap_accept", 32'(verdict_accept), 32'h1);
      idle(1);
      app_abort = 1'b1;
      meta_valid = 1'b1; meta_seq_num = 32'h4; meta_payload_len = 16'd2;
      cyc(c);
      check_val("abort_not_consumed", 32'(verdict_valid), 32'h0);
      check_val("abort_flags", 32'(tx_flags), 32'h14);
      check_val("abort_seq", tx_seq, 32'h1001);
      check_val("abort_ack", tx_ack, 32'h4);
      check_val("abort_state", 32'(conn_state), 32'd0);
      meta_valid = 1'b0; app_abort = 1'b0;
      idle(2);

      // reset while a request is pending
      tx_req_ready = 1'b0;
      send_seg(16'd5000, 32'h42, 32'h0, 8'h02, 16'd0);
      check_val("pre_rst_valid", 32'(tx_req_valid), 32'h1);
      rst = 1'b1;
      #1;
      check_val("async_rst_valid", 32'(tx_req_valid), 32'h0);
      check_val("async_rst_flags", 32'(tx_flags), 32'h0);
      check_val("async_rst_seq", tx_seq, 32'h0);
      check_val("async_rst_ack", tx_ack, 32'h0);
      check_val("async_rst_ports", {tx_src_port, tx_dst_port}, 32'h0);
      check_val("async_rst_state", 32'(conn_state), 32'h0);
      check_val("async_rst_ready", 32'(meta_ready), 32'h0);
      idle(1);
      rst = 1'b0;
      tx_req_ready = 1'b1;
      idle(2);

      // randomized traffic against the model
      c = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!meta_valid || c) begin
            meta_valid = ($urandom_range(0, 99) < 60);
            gen_seg();
         end
         tx_req_ready = ($urandom_range(0, 99) < 75);
         app_abort    = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 5) rx_window = 16'($urandom);
         cyc(c);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tcp_conn_ctrl.md
Name: tcp_conn_ctrl

Overview:
- Per-connection receive-side controller that sits downstream of the TCP header parser's metadata port (meta_valid/meta_ready).
- Runs a single passive-open TCP connection state machine and tracks rcv_nxt/snd_nxt.
- Issues a payload accept/drop verdict per consumed segment.
- Sequences control-segment transmit requests (SYN|ACK, ACK, FIN|ACK, RST|ACK) to the TX segment builder over a valid/ready handshake, with timeout-driven retransmission.

Parameters:
- LOCAL_PORT, 16'd80: only destination port served.
- ISS, 32'h0000_1000: initial send sequence number.
- RTO_CYCLES, 1000000: retransmit timeout in clk cycles.
- MAX_RETRIES, 3: retransmissions before abandoning to LISTEN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- meta_valid  in  1  parsed segment metadata valid
- meta_ready  out  1  metadata consumed when valid&&ready
- meta_src_port  in  16  peer port
- meta_dst_port  in  16  local port
- meta_seq_num  in  32  segment seq
- meta_ack_num  in  32  segment ack
- meta_flags  in  8  bit0 FIN, bit1 SYN, bit2 RST, bit3 PSH, bit4 ACK
- meta_window_size  in  16  peer window
- meta_payload_len  in  16  payload bytes
- rx_window  in  16  local advertised window
- app_abort  in  1  level request to abort connection
- tx_req_valid  out  1  control segment request
- tx_req_ready  in  1  TX builder accepts
- tx_flags  out  8  same bit map as meta_flags
- tx_seq  out  32  segment seq
- tx_ack  out  32  segment ack
- tx_src_port  out  16  always LOCAL_PORT
- tx_dst_port  out  16  latched peer port
- tx_window  out  16  rx_window sampled at request issue
- verdict_valid  out  1  one-cycle pulse
- verdict_accept  out  1  1 = forward payload, 0 = drop
- conn_state  out  2  LISTEN=0, SYN_RCVD=1, ESTABLISHED=2, LAST_ACK=3
- peer_window  out  16  last window from peer

Behaviour:
- Reset: all registered outputs are 0; conn_state=LISTEN; snd_nxt=ISS; rcv_nxt, peer port, timer and retry count are 0. meta_ready is 0 while rst is high. Reset mid-transfer drops any pending tx request immediately.
- meta_ready = !rst && !tx_req_valid && !(app_abort && conn_state!=LISTEN). Only one tx request is ever outstanding.
- tx handshake: all tx_* outputs are registered and held stable while tx_req_valid=1. A request is issued the cycle after the triggering event and cleared the cycle after tx_req_valid&&tx_req_ready.
- Verdict: verdict_valid pulses the cycle after every consumed segment. verdict_accept=1 only for in-order payload_len>0 accepted in ESTABLISHED.
- Filters, checked first:
  - dst_port!=LOCAL_PORT: drop, no tx, no state change.
  - Outside LISTEN, src_port!=peer port: drop, no tx.
  - RST with matching ports, outside LISTEN: go to LISTEN, no tx.
- All seq/ack arithmetic is modulo 2^32 and compares by equality only.
- LISTEN:
  - SYN=1, ACK=0: latch peer port; rcv_nxt=seq+1; tx SYN|ACK with seq=ISS, ack=rcv_nxt; snd_nxt=ISS+1; go to SYN_RCVD.
  - Anything else: drop, no tx.
- SYN_RCVD:
  - ACK=1 and ack==snd_nxt: go to ESTABLISHED; the same segment's payload/FIN is then processed under ESTABLISHED rules in the same consume.
  - Wrong ack: drop, no tx.
- ESTABLISHED:
  - Every matching segment updates peer_window.
  - seq==rcv_nxt, len>0, FIN=0: accept; rcv_nxt+=len; tx ACK with seq=snd_nxt, ack=rcv_nxt.
  - seq==rcv_nxt, len=0, FIN=0: no tx.
  - seq==rcv_nxt, FIN=1: accept if len>0; rcv_nxt+=len+1; tx FIN|ACK with seq=snd_nxt; snd_nxt+=1; go to LAST_ACK.
  - seq!=rcv_nxt: drop; tx duplicate ACK with ack=rcv_nxt; rcv_nxt unchanged.
- LAST_ACK:
  - ACK=1 and ack==snd_nxt: go to LISTEN, no tx.
  - Otherwise drop.
- Timer:
  - Counts only in SYN_RCVD/LAST_ACK while tx_req_valid=0; clears on any state change.
  - At RTO_CYCLES-1, the timer resets and retry increments. If retry<MAX_RETRIES, the last control segment is re-issued (same seq/ack). Otherwise the block goes to LISTEN with no tx.
  - Retry clears on state change.
- app_abort, outside LISTEN with tx_req_valid=0: tx RST|ACK with seq=snd_nxt, ack=rcv_nxt; go to LISTEN.
  - Abort has priority over a simultaneous meta_valid (meta_ready is forced 0).
  - If a tx request is pending, the abort waits for it to complete.
- Timer expiry in the same cycle as a valid consume: the consume wins and the timer resets.

Test Plan:
- Handshake: SYN, seq=0x100 from port 5000 → tx SYN|ACK (0x12), seq=0x1000, ack=0x101; then ACK with ack=0x1001 → conn_state=2.
- In-order data: seq=0x101, len=10 → verdict_accept=1; tx ACK (0x10), ack=0x10B. Then seq=0x101 again → verdict 0, duplicate ACK with ack=0x10B.
- Passive close: FIN|ACK, seq=0x10B, len=0 → tx FIN|ACK (0x11), seq=0x1001, ack=0x10C, state=3. Then ACK with ack=0x1002 → state=0.
- Backpressure: hold tx_req_ready=0 for 20 cycles with meta_valid=1 → meta_ready stays 0 and tx fields stay stable; release → exactly one request, next segment consumed.
- Retransmit: in SYN_RCVD with RTO_CYCLES=16, no ACK → SYN|ACK re-issued 3 times, then state=0.
- Wrap and abort: rcv_nxt=0xFFFFFFFC, len=8 → ack=0x00000004. Assert app_abort together with meta_valid → tx RST|ACK (0x14), state=0, segment not consumed. Assert rst mid-request → all outputs 0.
